// File: rtl/me_pkg.sv
// -----------------------------------------------------------------------------
// me_pkg
// Shared definitions for the modular-exponentiation core and its result
// collector: default word width and word count, the collector state encoding,
// and a K-bit word type.
// -----------------------------------------------------------------------------
package me_pkg;

    localparam int ME_K = 128;   // bits per result word
    localparam int ME_N = 16;    // words per result (ME_K*ME_N = 2048)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic [ME_K-1:0] word_t;

endpackage

// File: rtl/me_result_collector_if.sv
// -----------------------------------------------------------------------------
// me_result_collector_if
// Bundles the signals between the collector, the exponentiation core and the
// SoC bus wrapper.
//   me_start/me_result/me_valid : word stream from the core (plus arm pulse)
//   rd_en/rd_addr               : word-addressed read request
//   rd_data/rd_valid            : registered read response
//   result_flat                 : full K*N-bit result, word 0 in [K-1:0]
//   busy/done/done_pulse/ovf    : collector status
// modport master : the side that drives the stream and reads (core + wrapper)
// modport slave  : the collector itself
// -----------------------------------------------------------------------------
interface me_result_collector_if
    import me_pkg::*;
#(
    parameter int K  = ME_K,
    parameter int N  = ME_N,
    parameter int AW = $clog2(N)
);

    logic           me_start;
    logic [K-1:0]   me_result;
    logic           me_valid;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [K-1:0]   rd_data;
    logic           rd_valid;
    logic [K*N-1:0] result_flat;
    logic           busy;
    logic           done;
    logic           done_pulse;
    logic           ovf;

    modport master (
        output me_start, me_result, me_valid, rd_en, rd_addr,
        input  rd_data, rd_valid, result_flat, busy, done, done_pulse, ovf
    );

    modport slave (
        input  me_start, me_result, me_valid, rd_en, rd_addr,
        output rd_data, rd_valid, result_flat, busy, done, done_pulse, ovf
    );

endinterface

// File: rtl/me_result_collector.sv
// -----------------------------------------------------------------------------
// me_result_collector
// Captures the K-bit word stream from the modular-exponentiation core into an
// N-slot flop buffer. The core sends the most-significant word first, so the
// j-th accepted word lands in slot N-1-j. When the last word arrives the block
// enters DONE and raises done / done_pulse.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (clears buffer, returns to IDLE)
//   bus   : me_result_collector_if.slave (stream in, read port, status out)
// -----------------------------------------------------------------------------
module me_result_collector
    import me_pkg::*;
#(
    parameter int K  = ME_K,
    parameter int N  = ME_N,
    parameter int AW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    me_result_collector_if.slave bus
);

    localparam logic [AW:0] LAST_CNT = (AW+1)'(N - 1);
    localparam logic [AW:0] NUM_SLOT = (AW+1)'(N);

    state_t              state;
    logic [AW:0]         count;
    logic [N-1:0][K-1:0] slots;
    logic [K-1:0]        rd_data_q;
    logic                rd_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                done_pulse_q;
    logic                ovf_q;
    logic [AW-1:0]       wr_slot;

    // MSW-first stream: word j goes to slot N-1-j.
    assign wr_slot = AW'(N - 1) - count[AW-1:0];

    // ------------------------------------------------------------------
    // FSM, count and buffer. A start pulse wins over a word in the same
    // cycle; that word is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            slots        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            if (bus.me_start) begin
                state  <= COLLECT;
                count  <= '0;
                slots  <= '0;
                busy_q <= 1'b1;
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        // Stray words before arming are ignored.
                    end
                    COLLECT: begin
                        if (bus.me_valid) begin
                            slots[wr_slot] <= bus.me_result;
                            count          <= count + 1'b1;
                            if (count == LAST_CNT) begin
                                state        <= DONE;
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                                done_pulse_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        // Buffer is frozen; extra words only flag overflow.
                        if (bus.me_valid) ovf_q <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port. Sampling slots with the same edge that writes them gives
    // the pre-write value on a same-cycle collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= ({1'b0, bus.rd_addr} < NUM_SLOT) ? slots[bus.rd_addr] : '0;
            end
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.result_flat = slots;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.done_pulse  = done_pulse_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_me_result_collector.sv
// -----------------------------------------------------------------------------
// tb_me_result_collector
// Directed bench. Read responses go through a scoreboard queue checked by an
// independent monitor; status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_me_result_collector;
    import me_pkg::*;

    localparam int K = 128;
    localparam int N = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [K-1:0] exp_q[$];

    me_result_collector_if #(.K(K), .N(N)) bus ();

    me_result_collector #(.K(K), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Read-response monitor
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_extra: got rd_valid with data %h, want no response", bus.rd_data);
            end else begin
                logic [K-1:0] e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    bad++;
                    $display("FAIL rd_data: got %h want %h", bus.rd_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [K-1:0] act, logic [K-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_flat(string name, logic [K*N-1:0] act, logic [K*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int a = 0; a < N; a++) begin
                if (act[a*K +: K] !== exp[a*K +: K]) begin
                    $display("FAIL %s: word %0d got %h want %h", name, a, act[a*K +: K], exp[a*K +: K]);
                    break;
                end
            end
        end
    endtask

    // Full result when word j = base+j was sent MSW first: slot a holds base+(N-1-a)
    function automatic logic [K*N-1:0] full_exp(logic [K-1:0] base);
        logic [K*N-1:0] v;
        for (int a = 0; a < N; a++) v[a*K +: K] = base + K'(N - 1 - a);
        return v;
    endfunction

    task automatic rd(int addr, logic [K-1:0] e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'(addr);
        exp_q.push_back(e);
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic send(logic [K-1:0] w);
        bus.me_valid  = 1'b1;
        bus.me_result = w;
        step();
        bus.me_valid  = 1'b0;
    endtask

    task automatic arm();
        bus.me_start = 1'b1;
        step();
        bus.me_start = 1'b0;
    endtask

    task automatic final_checks(string tag);
        chk({tag, "_done"},  K'(bus.done), 1);
        chk({tag, "_dpls"},  K'(bus.done_pulse), 1);
        chk({tag, "_busy0"}, K'(bus.busy), 0);
        step();
        chk({tag, "_dpls_w"}, K'(bus.done_pulse), 0);
        chk({tag, "_done_l"}, K'(bus.done), 1);
        chk({tag, "_flat0"}, bus.result_flat[K-1:0], 128'h100F);
        chk_flat({tag, "_flat"}, bus.result_flat, full_exp(128'h1000));
        rd(0, 128'h100F);
        rd(15, 128'h1000);
        for (int a = 0; a < N; a++) rd(a, 128'h100F - K'(a));
    endtask

    initial begin
        bus.me_start  = 1'b0;
        bus.me_valid  = 1'b0;
        bus.me_result = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;

        // 1. Reset
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", K'(bus.busy), 0);
        chk("rst_done", K'(bus.done), 0);
        chk("rst_dpls", K'(bus.done_pulse), 0);
        chk("rst_ovf",  K'(bus.ovf), 0);
        chk("rst_rdv",  K'(bus.rd_valid), 0);
        chk("rst_rdd",  bus.rd_data, 0);
        chk_flat("rst_flat", bus.result_flat, '0);
        rst_n = 1'b1;
        step();
        rd(5, 0);

        // 2. Normal collection, back-to-back words
        arm();
        chk("arm_busy", K'(bus.busy), 1);
        chk("arm_done", K'(bus.done), 0);
        for (int j = 0; j < N; j++) begin
            bus.me_valid  = 1'b1;
            bus.me_result = 128'h1000 + K'(j);
            step();
            if (j < N - 1) begin
                chk("col_busy", K'(bus.busy), 1);
                chk("col_done", K'(bus.done), 0);
            end
        end
        bus.me_valid = 1'b0;
        final_checks("norm");

        // 3. Gapped valid
        arm();
        for (int j = 0; j < N; j++) begin
            bus.me_valid  = 1'b1;
            bus.me_result = 128'h1000 + K'(j);
            step();
            bus.me_valid  = 1'b0;
            if (j < N - 1) begin
                chk("gap_busy_a", K'(bus.busy), 1);
                step();
                chk("gap_busy_b", K'(bus.busy), 1);
            end
        end
        final_checks("gap");

        // 4. Overflow in DONE
        send(128'hDEAD);
        chk("ovf_set",  K'(bus.ovf), 1);
        chk("ovf_done", K'(bus.done), 1);
        chk_flat("ovf_flat", bus.result_flat, full_exp(128'h1000));
        step();
        chk("ovf_sticky", K'(bus.ovf), 1);
        rd(0, 128'h100F);
        arm();
        chk("rearm_ovf",  K'(bus.ovf), 0);
        chk("rearm_done", K'(bus.done), 0);
        chk("rearm_busy", K'(bus.busy), 1);
        chk_flat("rearm_flat", bus.result_flat, '0);

        // 5. Collision and restart (collector armed above)
        bus.me_valid  = 1'b1;
        bus.me_result = 128'h1000;
        bus.rd_en     = 1'b1;
        bus.rd_addr   = 4'd15;
        exp_q.push_back(0);            // same-cycle write: old value
        step();
        bus.me_valid = 1'b0;
        bus.rd_en    = 1'b0;
        rd(15, 128'h1000);
        send(128'h1001);
        send(128'h1002);
        bus.me_start  = 1'b1;
        bus.me_valid  = 1'b1;
        bus.me_result = 128'hBEEF;
        bus.rd_en     = 1'b1;
        bus.rd_addr   = 4'd15;
        exp_q.push_back(128'h1000);    // read sees buffer before the clear
        step();
        bus.me_start = 1'b0;
        bus.me_valid = 1'b0;
        bus.rd_en    = 1'b0;
        chk("rst5_busy", K'(bus.busy), 1);
        chk_flat("rst5_flat", bus.result_flat, '0);
        for (int a = 0; a < N; a++) rd(a, 0);
        for (int j = 0; j < N; j++) begin
            send(128'h2000 + K'(j));
            if (j == N - 2) chk("rst5_notdone", K'(bus.done), 0);
        end
        chk("rst5_done", K'(bus.done), 1);
        chk_flat("rst5_flat2", bus.result_flat, full_exp(128'h2000));
        rd(15, 128'h2000);
        rd(0, 128'h200F);

        // 6. Reset mid-collection
        arm();
        for (int j = 0; j < 8; j++) send(128'h3000 + K'(j));
        chk("mid_slot15", bus.result_flat[15*K +: K], 128'h3000);
        chk("mid_slot8",  bus.result_flat[8*K +: K], 128'h3007);
        rst_n = 1'b0;
        #2;
        chk("mrst_busy", K'(bus.busy), 0);
        chk("mrst_done", K'(bus.done), 0);
        chk_flat("mrst_flat", bus.result_flat, '0);
        step();
        rst_n = 1'b1;
        step();
        for (int j = 0; j < 3; j++) send(128'h4000 + K'(j));
        chk("idle_ovf",  K'(bus.ovf), 0);
        chk("idle_busy", K'(bus.busy), 0);
        chk("idle_done", K'(bus.done), 0);
        chk_flat("idle_flat", bus.result_flat, '0);
        rd(15, 0);

        step();
        step();
        chk("rd_pending", K'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
